// File: rtl/dma_pkg.sv
// Shared types and helpers for the multi-channel DMA burst scheduler.
// Contents:
//   BOUNDARY        AXI address boundary a burst may not cross (bytes)
//   dma_dir_e       transfer direction
//   dma_ch_state_e  per-channel control state
//   dma_cmd_t       burst command payload toward the AXI master datapath
//   burst_beats()   beats in the next burst given remaining length and addresses
package dma_pkg;

    localparam int unsigned BOUNDARY     = 4096;
    localparam int unsigned DMA_NUM_CH   = 4;
    localparam int unsigned DMA_ADDR_W   = 32;
    localparam int unsigned CMD_CH_W     = $clog2(DMA_NUM_CH);
    localparam int unsigned CMD_ADDR_W   = DMA_ADDR_W;

    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } dma_dir_e;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_ISSUE = 2'd1,
        CH_DRAIN = 2'd2,
        CH_DONE  = 2'd3
    } dma_ch_state_e;

    typedef struct packed {
        logic [CMD_CH_W-1:0]   ch;
        dma_dir_e              dir;
        logic [CMD_ADDR_W-1:0] src;
        logic [CMD_ADDR_W-1:0] dst;
        logic [7:0]            len;
        logic                  last;
    } dma_cmd_t;

    // Smallest of: remaining beats, burst cap, room before the next 4 KB line on src and on dst.
    // Offsets are beat-aligned, so the shift gives an exact beat count.
    function automatic logic [31:0] burst_beats(
        input logic [31:0] remaining,
        input logic [11:0] src_off,
        input logic [11:0] dst_off,
        input int unsigned beat_lg2,
        input int unsigned max_burst
    );
        logic [31:0] beats;
        logic [31:0] room_s;
        logic [31:0] room_d;
        room_s = (32'(BOUNDARY) - 32'(src_off)) >> beat_lg2;
        room_d = (32'(BOUNDARY) - 32'(dst_off)) >> beat_lg2;
        beats  = remaining;
        if (32'(max_burst) < beats) beats = 32'(max_burst);
        if (room_s < beats)         beats = room_s;
        if (room_d < beats)         beats = room_d;
        return beats;
    endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin arbiter over N requesters.
// Ports:
//   clk, rst     clock, async active-high reset (pointer returns to requester 0)
//   req          per-requester request
//   advance      the current grant is being taken this cycle
//   gnt_idx_c    index of the granted requester (combinational)
//   gnt_any_c    some requester is granted (combinational)
// The pointer marks the highest-priority requester; after a taken grant it moves
// to the one just after the winner.
module dma_rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [$clog2(N)-1:0] gnt_idx_c,
    output logic                 gnt_any_c
);

    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr_q;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N) s = s - N;
        return IDX_W'(s);
    endfunction

    // First requester at or after the pointer, wrapping.
    always_comb begin
        gnt_idx_c = '0;
        gnt_any_c = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            if (!gnt_any_c && req[wrap_idx(ptr_q, off)]) begin
                gnt_any_c = 1'b1;
                gnt_idx_c = wrap_idx(ptr_q, off);
            end
        end
    end

    // Priority pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance && gnt_any_c) begin
            ptr_q <= wrap_idx(gnt_idx_c, 1);
        end
    end

endmodule

// File: rtl/dma_mc_burst_scheduler.sv
// Multi-channel DMA command front-end: splits per-channel transfers into AXI4 INCR
// bursts (capped at MAX_BURST beats, never crossing a 4 KB line on src or dst),
// round-robins them onto one registered command port and tracks completions.
// Ports:
//   clk, rst                     clock, async active-high reset
//   ch_req_valid/ready           per-channel request handshake (ready = channel idle)
//   ch_req_dir/src/dst/len       per-channel request payload (len in beats, 0 allowed)
//   ch_abort                     stop issuing on a channel in ISSUE
//   cmd_valid/ready              burst command handshake toward the AXI master
//   cmd_ch/dir/src/dst/len/last  burst command payload (len = beats-1)
//   cpl_valid/ch/err             burst completion from the datapath
//   ch_busy/done/err             per-channel status (done = 1-cycle pulse, err sticky)
module dma_mc_burst_scheduler
    import dma_pkg::*;
#(
    parameter int unsigned NUM_CH     = DMA_NUM_CH,
    parameter int unsigned ADDR_W     = DMA_ADDR_W,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned MAX_OUTST  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         ch_req_valid,
    output logic [NUM_CH-1:0]         ch_req_ready,
    input  logic [NUM_CH-1:0]         ch_req_dir,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_req_src,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_req_dst,
    input  logic [NUM_CH*LEN_W-1:0]   ch_req_len,
    input  logic [NUM_CH-1:0]         ch_abort,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [$clog2(NUM_CH)-1:0] cmd_ch,
    output logic                      cmd_dir,
    output logic [ADDR_W-1:0]         cmd_src,
    output logic [ADDR_W-1:0]         cmd_dst,
    output logic [7:0]                cmd_len,
    output logic                      cmd_last,
    input  logic                      cpl_valid,
    input  logic [$clog2(NUM_CH)-1:0] cpl_ch,
    input  logic                      cpl_err,
    output logic [NUM_CH-1:0]         ch_busy,
    output logic [NUM_CH-1:0]         ch_done,
    output logic [NUM_CH-1:0]         ch_err
);

    localparam int unsigned CH_W     = $clog2(NUM_CH);
    localparam int unsigned BEAT_LG2 = $clog2(DATA_BYTES);
    localparam int unsigned OUT_W    = $clog2(MAX_OUTST + 1);
    localparam int unsigned SIZE_W   = $clog2(MAX_BURST + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(DATA_BYTES - 1));

    dma_ch_state_e     state_q [NUM_CH];
    dma_ch_state_e     state_d [NUM_CH];
    logic [ADDR_W-1:0] src_q   [NUM_CH];
    logic [ADDR_W-1:0] src_d   [NUM_CH];
    logic [ADDR_W-1:0] dst_q   [NUM_CH];
    logic [ADDR_W-1:0] dst_d   [NUM_CH];
    logic [LEN_W-1:0]  rem_q   [NUM_CH];
    logic [LEN_W-1:0]  rem_d   [NUM_CH];
    logic [OUT_W-1:0]  outst_q [NUM_CH];
    logic [OUT_W-1:0]  outst_d [NUM_CH];
    logic [NUM_CH-1:0] dir_q, dir_d;
    logic [NUM_CH-1:0] err_q, err_d;
    logic [NUM_CH-1:0] ready_q, busy_q, done_q;

    logic [NUM_CH-1:0] elig_c;
    logic [NUM_CH-1:0] issue_v, cpl_v;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic              load_c;
    logic              issue_c;
    logic [SIZE_W-1:0] g_beats;

    dma_cmd_t cmd_q, cmd_d;
    logic     cmd_valid_q, cmd_valid_d;

    // Channels that may put a burst on the command port this cycle.
    always_comb begin
        elig_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            elig_c[i] = (state_q[i] == CH_ISSUE) && (rem_q[i] != '0) &&
                        (outst_q[i] < OUT_W'(MAX_OUTST)) && !ch_abort[i];
        end
    end

    dma_rr_arbiter #(
        .N (NUM_CH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (elig_c),
        .advance   (load_c),
        .gnt_idx_c (gnt_idx),
        .gnt_any_c (gnt_any)
    );

    // Command register loads when empty or being drained; size of the granted burst.
    always_comb begin
        load_c  = !cmd_valid_q || cmd_ready;
        issue_c = load_c && gnt_any;
        g_beats = SIZE_W'(burst_beats(32'(rem_q[gnt_idx]), src_q[gnt_idx][11:0],
                                      dst_q[gnt_idx][11:0], BEAT_LG2, MAX_BURST));
    end

    // Per-channel issue and completion strobes.
    always_comb begin
        issue_v = '0;
        cpl_v   = '0;
        if (issue_c)   issue_v[gnt_idx] = 1'b1;
        if (cpl_valid) cpl_v[cpl_ch]    = 1'b1;
    end

    // Channel FSMs and address/length/outstanding bookkeeping.
    always_comb begin
        dir_d = dir_q;
        err_d = err_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            src_d[i]   = src_q[i];
            dst_d[i]   = dst_q[i];
            rem_d[i]   = rem_q[i];
            outst_d[i] = outst_q[i];

            if (issue_v[i]) begin
                src_d[i] = src_q[i] + (ADDR_W'(g_beats) << BEAT_LG2);
                dst_d[i] = dst_q[i] + (ADDR_W'(g_beats) << BEAT_LG2);
                rem_d[i] = rem_q[i] - LEN_W'(g_beats);
            end

            // A completion against zero outstanding is not counted.
            if (issue_v[i] && !(cpl_v[i] && outst_q[i] != '0)) begin
                outst_d[i] = outst_q[i] + OUT_W'(1);
            end else if (!issue_v[i] && cpl_v[i] && outst_q[i] != '0) begin
                outst_d[i] = outst_q[i] - OUT_W'(1);
            end

            unique case (state_q[i])
                CH_IDLE: begin
                    if (ch_req_valid[i]) begin
                        src_d[i]   = ch_req_src[i*ADDR_W +: ADDR_W] & ALIGN_MASK;
                        dst_d[i]   = ch_req_dst[i*ADDR_W +: ADDR_W] & ALIGN_MASK;
                        rem_d[i]   = ch_req_len[i*LEN_W +: LEN_W];
                        dir_d[i]   = ch_req_dir[i];
                        err_d[i]   = 1'b0;
                        state_d[i] = (ch_req_len[i*LEN_W +: LEN_W] == '0) ? CH_DONE : CH_ISSUE;
                    end
                end
                CH_ISSUE: begin
                    if (ch_abort[i]) begin
                        err_d[i]   = 1'b1;
                        state_d[i] = CH_DRAIN;
                    end else if (rem_d[i] == '0) begin
                        state_d[i] = CH_DRAIN;
                    end
                end
                CH_DRAIN: begin
                    if (outst_q[i] == '0) state_d[i] = CH_DONE;
                end
                CH_DONE: begin
                    state_d[i] = CH_IDLE;
                end
            endcase

            // Error sets take priority over the clear on accept.
            if (cpl_v[i] && (cpl_err || outst_q[i] == '0)) err_d[i] = 1'b1;
        end
    end

    // Next command register contents.
    always_comb begin
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        if (load_c) cmd_valid_d = gnt_any;
        if (issue_c) begin
            cmd_d.ch   = CMD_CH_W'(gnt_idx);
            cmd_d.dir  = dma_dir_e'(dir_q[gnt_idx]);
            cmd_d.src  = CMD_ADDR_W'(src_q[gnt_idx]);
            cmd_d.dst  = CMD_ADDR_W'(dst_q[gnt_idx]);
            cmd_d.len  = 8'(g_beats - SIZE_W'(1));
            cmd_d.last = (LEN_W'(g_beats) == rem_q[gnt_idx]);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= CH_IDLE;
                src_q[i]   <= '0;
                dst_q[i]   <= '0;
                rem_q[i]   <= '0;
                outst_q[i] <= '0;
            end
            dir_q       <= '0;
            err_q       <= '0;
            ready_q     <= '1;
            busy_q      <= '0;
            done_q      <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                src_q[i]   <= src_d[i];
                dst_q[i]   <= dst_d[i];
                rem_q[i]   <= rem_d[i];
                outst_q[i] <= outst_d[i];
                ready_q[i] <= (state_d[i] == CH_IDLE);
                busy_q[i]  <= (state_d[i] != CH_IDLE);
                done_q[i]  <= (state_d[i] == CH_DONE);
            end
            dir_q       <= dir_d;
            err_q       <= err_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    assign ch_req_ready = ready_q;
    assign ch_busy      = busy_q;
    assign ch_done      = done_q;
    assign ch_err       = err_q;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_ch       = CH_W'(cmd_q.ch);
    assign cmd_dir      = cmd_q.dir;
    assign cmd_src      = ADDR_W'(cmd_q.src);
    assign cmd_dst      = ADDR_W'(cmd_q.dst);
    assign cmd_len      = cmd_q.len;
    assign cmd_last     = cmd_q.last;

endmodule

// File: tb/tb_dma_mc_burst_scheduler.sv
// Self-checking bench for dma_mc_burst_scheduler: table of transfers plus hand
// sequences for interleave/stall, outstanding cap, abort, spurious completion and reset.
module tb_dma_mc_burst_scheduler;

    localparam int NC = 4;
    localparam int AW = 32;
    localparam int LW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NC-1:0]     ch_req_valid = '0;
    logic [NC-1:0]     ch_req_ready;
    logic [NC-1:0]     ch_req_dir = '0;
    logic [NC*AW-1:0]  ch_req_src = '0;
    logic [NC*AW-1:0]  ch_req_dst = '0;
    logic [NC*LW-1:0]  ch_req_len = '0;
    logic [NC-1:0]     ch_abort = '0;
    logic              cmd_valid;
    logic              cmd_ready = 1'b1;
    logic [1:0]        cmd_ch;
    logic              cmd_dir;
    logic [AW-1:0]     cmd_src, cmd_dst;
    logic [7:0]        cmd_len;
    logic              cmd_last;
    logic              cpl_valid = 1'b0;
    logic [1:0]        cpl_ch = '0;
    logic              cpl_err = 1'b0;
    logic [NC-1:0]     ch_busy, ch_done, ch_err;

    always #5 clk = ~clk;

    dma_mc_burst_scheduler dut (
        .clk(clk), .rst(rst),
        .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready), .ch_req_dir(ch_req_dir),
        .ch_req_src(ch_req_src), .ch_req_dst(ch_req_dst), .ch_req_len(ch_req_len),
        .ch_abort(ch_abort),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_dir(cmd_dir),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_last(cmd_last),
        .cpl_valid(cpl_valid), .cpl_ch(cpl_ch), .cpl_err(cpl_err),
        .ch_busy(ch_busy), .ch_done(ch_done), .ch_err(ch_err)
    );

    typedef struct {
        logic          dir;
        logic [31:0]   src;
        logic [31:0]   dst;
        logic [7:0]    len;
        logic          last;
    } exp_cmd_t;

    typedef struct {
        int   ch;
        logic err;
    } cpl_t;

    typedef struct {
        int          ch;
        logic        dir;
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        logic        inj;
        int          exp_bursts;
        logic        exp_err;
    } vec_t;

    exp_cmd_t exp_q [NC][$];
    cpl_t     cpl_q [$];
    int       got_ch [$];
    int       acc_cnt [NC];
    int       vec_cnt = 0;
    int       err_cnt = 0;
    logic     cpl_en  = 1'b1;
    logic     inj_err = 1'b0;
    cpl_t     cpl_cur;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference burst split: min(remaining, 16, beats to next 4 KB line on src and dst).
    task automatic push_xfer(input int ch, input logic dir, input logic [31:0] src,
                             input logic [31:0] dst, input int len, input int maxb);
        logic [31:0] s, d;
        int rem, b, rs, rd, n;
        exp_cmd_t e;
        s = src & ~32'h3;
        d = dst & ~32'h3;
        rem = len;
        n = 0;
        while (rem > 0 && n < maxb) begin
            rs = (4096 - int'(s % 4096)) / 4;
            rd = (4096 - int'(d % 4096)) / 4;
            b = (rem > 16) ? 16 : rem;
            if (rs < b) b = rs;
            if (rd < b) b = rd;
            e.dir = dir; e.src = s; e.dst = d; e.len = 8'(b - 1); e.last = (b == rem);
            exp_q[ch].push_back(e);
            s = s + 32'(b * 4);
            d = d + 32'(b * 4);
            rem = rem - b;
            n++;
        end
    endtask

    // Command monitor: scoreboard compare, stall-hold check, auto completion.
    logic          prev_stall = 1'b0;
    logic [127:0]  prev_fields;
    exp_cmd_t      mon_e;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && cmd_valid)
                chk("hold_fields", {cmd_ch, cmd_dir, cmd_src, cmd_dst, cmd_len, cmd_last}, prev_fields);
            if (cmd_valid && cmd_ready) begin
                acc_cnt[cmd_ch]++;
                got_ch.push_back(int'(cmd_ch));
                chk("cmd_expected", 128'(exp_q[cmd_ch].size() != 0), 1);
                if (exp_q[cmd_ch].size() != 0) begin
                    mon_e = exp_q[cmd_ch].pop_front();
                    chk("cmd_fields", {cmd_dir, cmd_src, cmd_dst, cmd_len, cmd_last},
                        {mon_e.dir, mon_e.src, mon_e.dst, mon_e.len, mon_e.last});
                end
                cpl_q.push_back('{ch: int'(cmd_ch), err: inj_err});
            end
            prev_stall  = cmd_valid && !cmd_ready;
            prev_fields = {cmd_ch, cmd_dir, cmd_src, cmd_dst, cmd_len, cmd_last};
        end
    end

    // Completion driver.
    always @(posedge clk) begin
        #1;
        if (cpl_en && !rst && cpl_q.size() > 0) begin
            cpl_cur   = cpl_q.pop_front();
            cpl_valid = 1'b1;
            cpl_ch    = 2'(cpl_cur.ch);
            cpl_err   = cpl_cur.err;
        end else begin
            cpl_valid = 1'b0;
            cpl_err   = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int ch, input logic dir, input logic [31:0] src,
                           input logic [31:0] dst, input logic [15:0] len);
        ch_req_dir[ch]            = dir;
        ch_req_src[ch*AW +: AW]   = src;
        ch_req_dst[ch*AW +: AW]   = dst;
        ch_req_len[ch*LW +: LW]   = len;
        ch_req_valid[ch]          = 1'b1;
    endtask

    task automatic wait_cmd();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_valid && n < 50);
        chk("cmd_valid_seen", cmd_valid, 1);
    endtask

    task automatic wait_done(input int ch, input logic exp_err, output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!ch_done[ch] && cyc < 300);
        chk("done_pulse", ch_done[ch], 1);
        chk("done_err", ch_err[ch], exp_err);
        @(negedge clk);
        chk("done_1cycle", ch_done[ch], 0);
        chk("ready_after_done", ch_req_ready[ch], 1);
    endtask

    task automatic run_xfer(input vec_t v);
        int a0, cyc;
        a0 = acc_cnt[v.ch];
        inj_err = v.inj;
        push_xfer(v.ch, v.dir, v.src, v.dst, int'(v.len), 1000);
        set_req(v.ch, v.dir, v.src, v.dst, v.len);
        step();
        ch_req_valid = '0;
        wait_done(v.ch, v.exp_err, cyc);
        chk("burst_count", acc_cnt[v.ch] - a0, v.exp_bursts);
        chk("sb_drained", exp_q[v.ch].size(), 0);
        if (v.len == 0) chk("len0_latency", cyc, 1);
        step();
        inj_err = 1'b0;
    endtask

    task automatic clear_sb();
        for (int c = 0; c < NC; c++) exp_q[c].delete();
        cpl_q.delete();
        got_ch.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, ch_req_ready, 4'hF);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_busy"}, ch_busy, 0);
        chk({tag, "_done"}, ch_done, 0);
        chk({tag, "_err"}, ch_err, 0);
    endtask

    vec_t tbl [7];
    int   exp_order [6] = '{0, 2, 0, 2, 0, 2};

    initial begin
        int a0, cyc, n;
        logic [3:0] seen;
        for (int c = 0; c < NC; c++) acc_cnt[c] = 0;

        tbl[0] = '{0, 1'b1, 32'h0000, 32'h0400, 16'd16, 1'b0, 1, 1'b0};
        tbl[1] = '{0, 1'b0, 32'h0000, 32'h0800, 16'd40, 1'b0, 3, 1'b0};
        tbl[2] = '{1, 1'b1, 32'h0FF0, 32'h2000, 16'd16, 1'b0, 2, 1'b0};
        tbl[3] = '{2, 1'b0, 32'h0123, 32'h5F80, 16'd20, 1'b0, 2, 1'b0};
        tbl[4] = '{3, 1'b1, 32'h0FC0, 32'h0FF8, 16'd5,  1'b0, 2, 1'b0};
        tbl[5] = '{2, 1'b0, 32'h0010, 32'h0020, 16'd0,  1'b0, 0, 1'b0};
        tbl[6] = '{3, 1'b0, 32'h0040, 32'h0080, 16'd8,  1'b1, 1, 1'b1};

        // Reset values.
        #1 rst = 1'b1;
        #1 check_idle_outputs("reset");
        step();
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_xfer(tbl[i]);

        // Outstanding cap: hold completions, only 4 bursts may be in flight.
        a0 = acc_cnt[0];
        cpl_en = 1'b0;
        push_xfer(0, 1'b1, 32'h0, 32'h8000, 100, 1000);
        set_req(0, 1'b1, 32'h0, 32'h8000, 16'd100);
        step();
        ch_req_valid = '0;
        repeat (20) step();
        chk("outst_cap", acc_cnt[0] - a0, 4);
        cpl_en = 1'b1;
        wait_done(0, 1'b0, cyc);
        chk("outst_total", acc_cnt[0] - a0, 7);
        step();

        // Spurious completion on an idle channel sets its error; next request clears it.
        cpl_q.push_back('{ch: 1, err: 1'b0});
        repeat (3) step();
        chk("spurious_err", ch_err[1], 1);
        run_xfer('{1, 1'b0, 32'h0100, 32'h0200, 16'd8, 1'b0, 1, 1'b0});

        // Reset restores the arbiter pointer, then ch0/ch2 interleave with a 3-cycle stall.
        rst = 1'b1;
        clear_sb();
        #1 check_idle_outputs("reset2");
        step();
        rst = 1'b0;
        step();
        cmd_ready = 1'b0;
        push_xfer(0, 1'b0, 32'h0000, 32'h1000, 48, 1000);
        push_xfer(2, 1'b1, 32'h3000, 32'h4000, 48, 1000);
        set_req(0, 1'b0, 32'h0000, 32'h1000, 16'd48);
        set_req(2, 1'b1, 32'h3000, 32'h4000, 16'd48);
        step();
        ch_req_valid = '0;
        wait_cmd();
        repeat (3) @(negedge clk);
        step();
        cmd_ready = 1'b1;
        seen = '0;
        n = 0;
        do begin @(negedge clk); seen = seen | ch_done; n++; end while (seen != 4'b0101 && n < 300);
        chk("interleave_done", seen, 4'b0101);
        chk("interleave_count", got_ch.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < got_ch.size()) chk("interleave_order", got_ch[i], exp_order[i]);
        repeat (2) step();

        // Abort after the first command is accepted.
        a0 = acc_cnt[3];
        cmd_ready = 1'b0;
        push_xfer(3, 1'b1, 32'h0, 32'h2000, 64, 1);
        set_req(3, 1'b1, 32'h0, 32'h2000, 16'd64);
        step();
        ch_req_valid = '0;
        wait_cmd();
        step();
        ch_abort[3] = 1'b1;
        cmd_ready   = 1'b1;
        step();
        ch_abort[3] = 1'b0;
        wait_done(3, 1'b1, cyc);
        repeat (3) step();
        chk("abort_bursts", acc_cnt[3] - a0, 1);
        chk("abort_sb", exp_q[3].size(), 0);
        run_xfer('{3, 1'b1, 32'h0200, 32'h0300, 16'd4, 1'b0, 1, 1'b0});

        // Reset while a command is pending.
        cmd_ready = 1'b0;
        push_xfer(0, 1'b0, 32'h0, 32'h100, 32, 1000);
        set_req(0, 1'b0, 32'h0, 32'h100, 16'd32);
        step();
        ch_req_valid = '0;
        wait_cmd();
        #2 rst = 1'b1;
        #1;
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_ready", ch_req_ready, 4'hF);
        chk("rst_busy", ch_busy, 0);
        clear_sb();
        step();
        rst = 1'b0;
        cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_done", ch_done, 0);
        chk("post_rst_cmd_valid", cmd_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
